// File: rtl/intersection_pkg.sv
`default_nettype none
// ============================================================================
// Module   : intersection_pkg
// Brief    : Shared state encoding, lamp bit positions and direction codes
//            for the intersection controller.
// Revision : 1.0 - initial release
// ============================================================================
package intersection_pkg;

  // Controller phases; the encoding is exported on the phase debug port
  typedef enum logic [2:0] {
    INIT_RED  = 3'd0,
    NS_GREEN  = 3'd1,
    NS_YELLOW = 3'd2,
    NS_CLEAR  = 3'd3,
    EW_GREEN  = 3'd4,
    EW_YELLOW = 3'd5,
    EW_CLEAR  = 3'd6,
    EMERG     = 3'd7
  } state_t;

  // Lamp bit positions within a 4-bit signal head
  localparam int WALK   = 3;
  localparam int GREEN  = 2;
  localparam int YELLOW = 1;
  localparam int RED    = 0;

  // Single-lamp patterns built from the bit positions
  localparam logic [3:0] LAMP_WALK   = 4'(1 << WALK);
  localparam logic [3:0] LAMP_GREEN  = 4'(1 << GREEN);
  localparam logic [3:0] LAMP_YELLOW = 4'(1 << YELLOW);
  localparam logic [3:0] LAMP_RED    = 4'(1 << RED);

  // Direction codes used for the emergency direction
  localparam logic DIR_NS = 1'b0;
  localparam logic DIR_EW = 1'b1;

endpackage
`default_nettype wire

// File: rtl/phase_timer.sv
`default_nettype none
// ============================================================================
// Module   : phase_timer
// Brief    : Per-phase cycle counter. Cleared on state entry, saturating,
//            with a flag that marks the last cycle of a phase of length dur.
// Revision : 1.0 - initial release
// ============================================================================
module phase_timer #(
  parameter int CNT_W = 8
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             clear,
  input  logic [CNT_W-1:0] dur,
  output logic [CNT_W-1:0] count,
  output logic             at_dur
);

  // Count up from zero after each clear, holding at all-ones
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (count != '1) begin
      count <= count + CNT_W'(1);
    end
  end

  // A phase of duration dur ends on the edge where the count reads dur-1
  assign at_dur = (count == (dur - CNT_W'(1)));

endmodule
`default_nettype wire

// File: rtl/intersection_controller.sv
`default_nettype none
// ============================================================================
// Module   : intersection_controller
// Brief    : Moore FSM sequencing the NS and EW signal heads, with request
//            latches that shorten a green and emergency pre-emption.
// Revision : 1.0 - initial release
// ============================================================================
module intersection_controller
  import intersection_pkg::*;
#(
  parameter int GREEN_MIN   = 4,
  parameter int GREEN_MAX   = 10,
  parameter int YELLOW_TIME = 2,
  parameter int ALLRED_TIME = 1,
  parameter int CNT_W       = 8
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       emergency,
  input  logic       emergency_dir,
  input  logic       ns_req,
  input  logic       ew_req,
  output logic [3:0] NSout,
  output logic [3:0] EWout,
  output logic [2:0] phase
);

  localparam logic [CNT_W-1:0] GMIN      = CNT_W'(GREEN_MIN);
  localparam logic [CNT_W-1:0] GMIN_LAST = CNT_W'(GREEN_MIN - 1);
  localparam logic [CNT_W-1:0] GMAX      = CNT_W'(GREEN_MAX);
  localparam logic [CNT_W-1:0] YEL       = CNT_W'(YELLOW_TIME);
  localparam logic [CNT_W-1:0] ALLRED    = CNT_W'(ALLRED_TIME);

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] timer;
  logic [CNT_W-1:0] dur;
  logic             timer_done;
  logic             ns_pend;
  logic             ew_pend;
  logic             edir;
  logic             edir_valid;
  logic             preempt;
  logic             eff_dir;
  logic             entering_ns_green;
  logic             entering_ew_green;

  // Once latched, the emergency direction ignores further input changes
  assign eff_dir = edir_valid ? edir : emergency_dir;

  assign entering_ns_green = (state_nxt == NS_GREEN) && (state != NS_GREEN);
  assign entering_ew_green = (state_nxt == EW_GREEN) && (state != EW_GREEN);

  // Duration of the current phase; greens use the maximum as their hard limit
  always_comb begin
    dur = ALLRED;
    case (state)
      NS_GREEN, EW_GREEN:   dur = GMAX;
      NS_YELLOW, EW_YELLOW: dur = YEL;
      default:              dur = ALLRED;
    endcase
  end

  phase_timer #(
    .CNT_W (CNT_W)
  ) u_phase_timer (
    .clock   (clock),
    .reset_n (reset_n),
    .clear   (state_nxt != state),
    .dur     (dur),
    .count   (timer),
    .at_dur  (timer_done)
  );

  // State register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= INIT_RED;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic: rotation, early green exit on demand, pre-emption
  always_comb begin
    state_nxt = state;
    case (state)
      INIT_RED: begin
        if (timer_done) state_nxt = (emergency || preempt) ? EMERG : NS_GREEN;
      end
      NS_GREEN: begin
        if (emergency) begin
          state_nxt = (eff_dir == DIR_NS) ? EMERG : NS_YELLOW;
        end else if (((timer >= GMIN_LAST) && ew_pend) || timer_done) begin
          state_nxt = NS_YELLOW;
        end
      end
      NS_YELLOW: begin
        if (timer_done) state_nxt = NS_CLEAR;
      end
      NS_CLEAR: begin
        if (timer_done) state_nxt = (emergency || preempt) ? EMERG : EW_GREEN;
      end
      EW_GREEN: begin
        if (emergency) begin
          state_nxt = (eff_dir == DIR_EW) ? EMERG : EW_YELLOW;
        end else if (((timer >= GMIN_LAST) && ns_pend) || timer_done) begin
          state_nxt = EW_YELLOW;
        end
      end
      EW_YELLOW: begin
        if (timer_done) state_nxt = EW_CLEAR;
      end
      EW_CLEAR: begin
        if (timer_done) state_nxt = (emergency || preempt) ? EMERG : NS_GREEN;
      end
      EMERG: begin
        if (!emergency) state_nxt = (edir == DIR_NS) ? NS_YELLOW : EW_YELLOW;
      end
      default: state_nxt = INIT_RED;
    endcase
  end

  // Service-request latches; entry into the own green clears, own green ignores
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ns_pend <= 1'b0;
      ew_pend <= 1'b0;
    end else begin
      if (entering_ns_green)                  ns_pend <= 1'b0;
      else if (ns_req && (state != NS_GREEN)) ns_pend <= 1'b1;
      if (entering_ew_green)                  ew_pend <= 1'b0;
      else if (ew_req && (state != EW_GREEN)) ew_pend <= 1'b1;
    end
  end

  // Emergency direction latch, held until normal rotation reaches a green
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      edir       <= DIR_NS;
      edir_valid <= 1'b0;
    end else if (entering_ns_green || entering_ew_green) begin
      edir       <= DIR_NS;
      edir_valid <= 1'b0;
    end else if (emergency && (state != EMERG) && !edir_valid) begin
      edir       <= emergency_dir;
      edir_valid <= 1'b1;
    end
  end

  // Remembers a pre-emption so a short emergency pulse still reaches EMERG
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      preempt <= 1'b0;
    end else if (state_nxt == EMERG) begin
      preempt <= 1'b0;
    end else if (emergency && (state != EMERG)) begin
      preempt <= 1'b1;
    end
  end

  // Lamp decode from state and timer only
  always_comb begin
    NSout = LAMP_RED;
    EWout = LAMP_RED;
    case (state)
      NS_GREEN:  NSout = (timer < GMIN) ? (LAMP_GREEN | LAMP_WALK) : LAMP_GREEN;
      NS_YELLOW: NSout = LAMP_YELLOW;
      EW_GREEN:  EWout = (timer < GMIN) ? (LAMP_GREEN | LAMP_WALK) : LAMP_GREEN;
      EW_YELLOW: EWout = LAMP_YELLOW;
      EMERG: begin
        if (edir == DIR_NS) NSout = LAMP_GREEN;
        else                EWout = LAMP_GREEN;
      end
      default: begin
        NSout = LAMP_RED;
        EWout = LAMP_RED;
      end
    endcase
  end

  assign phase = state;

endmodule
`default_nettype wire

// File: doc/intersection_controller.md
# intersection_controller

Moore-style controller that sequences the NS and EW signal heads of one intersection and arbitrates right-of-way between the two approaches. It drives the 4-bit `NSout` and `EWout` lamp buses, accepts per-direction vehicle/pedestrian requests, and pre-empts normal rotation on the `emergency` input. The block replaces free-running per-direction light modules: a single FSM guarantees that the two directions are never green at the same time.

## Interface
- `GREEN_MIN`, 4: minimum green duration in cycles; the walk lamp is on for this period.
- `GREEN_MAX`, 10: maximum green duration in cycles.
- `YELLOW_TIME`, 2: yellow duration in cycles.
- `ALLRED_TIME`, 1: all-red clearance duration in cycles.
- `CNT_W`, 8: phase timer width. Every timing parameter must satisfy 1 ≤ param < 2^CNT_W, and GREEN_MIN ≤ GREEN_MAX.
- `clock` in 1: single clock; all state updates on the rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `emergency` in 1: pre-emption request, level-sensitive, sampled synchronously.
- `emergency_dir` in 1: direction to clear for the emergency vehicle (0 = NS, 1 = EW).
- `ns_req` in 1: NS service request; a one-cycle pulse is sufficient.
- `ew_req` in 1: EW service request; a one-cycle pulse is sufficient.
- `NSout` out 4: NS lamps; bit3 = walk, bit2 = green, bit1 = yellow, bit0 = red.
- `EWout` out 4: EW lamps; same encoding as `NSout`.
- `phase` out 3: current FSM state encoding, for debug and bench checking.

## Operation
- States: INIT_RED, NS_GREEN, NS_YELLOW, NS_CLEAR, EW_GREEN, EW_YELLOW, EW_CLEAR, EMERG.
- Phase timer resets to 0 on every state entry and increments each cycle. A state of duration D exits on the edge where the timer equals D-1.
- Lamp decode:
  - Green state: own head 0100, or 1100 while timer < GREEN_MIN. Other head 0001.
  - Yellow state: own head 0010, other head 0001.
  - CLEAR and INIT_RED: both heads 0001.
  - EMERG: the latched direction shows 0100; the other shows 0001.
- Pending latches `ns_pend` and `ew_pend`:
  - Set by `ns_req` / `ew_req`.
  - Cleared on entry to that direction's green.
  - A request during the direction's own green is ignored.
- Normal sequence: INIT_RED (ALLRED_TIME) → NS_GREEN → NS_YELLOW (YELLOW_TIME) → NS_CLEAR (ALLRED_TIME) → EW_GREEN → EW_YELLOW → EW_CLEAR → NS_GREEN.
- Green exit: leave when (timer ≥ GREEN_MIN-1 and the opposing pend is set) or timer == GREEN_MAX-1. A green therefore lasts between GREEN_MIN and GREEN_MAX cycles.
- Emergency pre-emption. When `emergency` is high at an edge outside EMERG, latch `emergency_dir` into `edir` if not already latched, then:
  - Green of `edir`: go to EMERG at this edge.
  - Green of the other direction: truncate the green immediately (GREEN_MIN is waived), go to yellow, then CLEAR, then EMERG.
  - Yellow, CLEAR or INIT_RED: complete the current state with full duration, then go to EMERG.
- Changes to `emergency_dir` after `edir` is latched are ignored until the block returns to normal operation.
- EMERG: hold while `emergency` is high. On deassert, go to `edir`'s yellow, then CLEAR, then the other direction's green (normal rotation resumes) and release `edir`.
- `emergency` deasserted before EMERG is reached: the in-flight yellow/clear sequence still completes; EMERG is entered for one cycle, then exits as above.
- Safety invariant: the green or walk bits of both heads are never set together. Every direction change passes through yellow and then CLEAR.

## Timing
- Reset (asynchronous assert): INIT_RED, timer = 0, pend latches = 0, `edir` cleared, `NSout` = `EWout` = 4'b0001, `phase` = INIT_RED.
- Reset deassertion is synchronized by the surrounding logic; the first active edge counts as timer 0 of INIT_RED.
- Outputs are registered or decoded purely from state and timer; there is no combinational path from inputs to outputs.
- Request latency: a request sampled at edge k can affect the green exit decision at edge k+1.
- Emergency latency from a green of the other direction: yellow is visible after the sampling edge. The `edir` green appears YELLOW_TIME + ALLRED_TIME cycles later.
- Timer saturates at 2^CNT_W-1; in practice only EMERG reaches this.
- Asynchronous reset mid-phase, including mid-EMERG, forces INIT_RED with no yellow.

## Structure
- Package `intersection_pkg`: state enum, lamp bit-position constants (WALK = 3, GREEN = 2, YELLOW = 1, RED = 0), direction constants (DIR_NS = 0, DIR_EW = 1).
- One sub-module, `phase_timer`: clear-on-entry counter with saturation and an `at(D)` compare.
- Remaining logic (FSM, pend latches, `edir` latch, lamp decode) lives in `intersection_controller`.

## Test plan
All scenarios use default parameters.
1. Reset, no requests → INIT_RED for 1 cycle; NS 1100 ×4, 0100 ×6, 0010 ×2; all-red ×1; EW green ×10; the rotation repeats.
2. `ew_req` pulse at NS_GREEN timer 1 → NS green lasts exactly 4 cycles, then yellow; `ew_pend` clears on EW_GREEN entry.
3. `ew_req` at NS_GREEN timer 6 → NS yellow follows at the next edge.
4. `emergency` = 1, `emergency_dir` = 1 during NS_GREEN timer 2 → NS yellow 2, all-red 1, EW 0100 held. Toggling `emergency_dir` during EMERG has no effect. Deassert → EW yellow 2, all-red 1, NS green.
5. `emergency` pulse of 1 cycle during EW_CLEAR → CLEAR completes, EMERG ×1 cycle, then the `edir` yellow/clear sequence.
6. `reset_n` low for a partial cycle during EMERG → outputs are 0001/0001 immediately (before the next edge) and the normal sequence restarts.
- Continuous checker on all scenarios: both heads are never green simultaneously, and a yellow always precedes red.
